// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit that owns the HI/LO registers, with MTHI/MTLO writes.
// Build option MULDIV_EARLY_TERM_EN: multiplies leave CALC once the remaining multiplier bits are zero.
//
// state | meaning
// IDLE  | waiting for Start; MTHI/MTLO accepted here
// CALC  | one shift-add / shift-subtract group per cycle
// FIX   | apply result sign, write Hi/Lo
// DONE  | Done pulse; a new Start is accepted as in IDLE
module muldiv_unit #(
   parameter int DATA_W        = 32,
   parameter int STEPS_PER_CLK = 1
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Start,
   input  logic [2:0]        Op,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic              Flush,
   output logic              Busy,
   output logic              Done,
   output logic              DivByZero,
   output logic [DATA_W-1:0] Hi,
   output logic [DATA_W-1:0] Lo
);

   localparam int N     = DATA_W / STEPS_PER_CLK;
   localparam int CNT_W = $clog2(N + 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t                state, state_n;
   logic [CNT_W-1:0]      cnt;
   logic [2*DATA_W-1:0]   acc, acc_n;
   logic [2*DATA_W-1:0]   opd, opd_n;
   logic [DATA_W-1:0]     sreg, sreg_n;
   logic                  is_div, neg_q, neg_r, dz_q;
   logic                  op_mul, op_div, op_signed, dz, accept, last, early;
   logic                  a_neg, b_neg;
   logic [DATA_W-1:0]     a_mag, b_mag;
   logic [DATA_W:0]       shifted;
   logic [2*DATA_W-1:0]   prod_fix;
   logic [DATA_W-1:0]     quot_fix, rem_fix;

   assign op_mul    = (Op == 3'b000) || (Op == 3'b001);
   assign op_div    = (Op == 3'b010) || (Op == 3'b011);
   assign op_signed = ~Op[0];
   assign dz        = op_div && (B == '0);
   assign accept    = Start && !Flush && ((state == S_IDLE) || (state == S_DONE));

   assign a_neg = op_signed & A[DATA_W-1];
   assign b_neg = op_signed & B[DATA_W-1];
   assign a_mag = a_neg ? -A : A;
   assign b_mag = b_neg ? -B : B;

   // Multiply accumulates a left-shifting multiplicand; divide keeps the
   // partial remainder in acc and shifts the dividend/quotient through sreg.
   always_comb begin
      acc_n   = acc;
      opd_n   = opd;
      sreg_n  = sreg;
      shifted = '0;
      for (int i = 0; i < STEPS_PER_CLK; i++) begin
         if (is_div) begin
            shifted = {acc_n[DATA_W-1:0], sreg_n[DATA_W-1]};
            sreg_n  = {sreg_n[DATA_W-2:0], 1'b0};
            if (shifted >= {1'b0, opd_n[DATA_W-1:0]}) begin
               shifted   = shifted - {1'b0, opd_n[DATA_W-1:0]};
               sreg_n[0] = 1'b1;
            end
            acc_n = {{(DATA_W-1){1'b0}}, shifted};
         end else begin
            if (sreg_n[0])
               acc_n = acc_n + opd_n;
            opd_n  = opd_n << 1;
            sreg_n = sreg_n >> 1;
         end
      end
   end

`ifdef MULDIV_EARLY_TERM_EN
   assign early = !is_div && (sreg_n == '0);
`else
   assign early = 1'b0;
`endif

   assign last = (cnt == CNT_W'(1)) || early;

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE, S_DONE: begin
            state_n = S_IDLE;
            if (accept && (op_mul || op_div))
               state_n = dz ? S_DONE : S_CALC;
         end
         S_CALC:  if (last) state_n = S_FIX;
         S_FIX:   state_n = S_DONE;
         default: state_n = S_IDLE;
      endcase
      if (Flush)
         state_n = S_IDLE;
   end

   assign prod_fix = neg_q ? -acc : acc;
   assign quot_fix = neg_q ? -sreg : sreg;
   assign rem_fix  = neg_r ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         acc    <= '0;
         opd    <= '0;
         sreg   <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         dz_q   <= 1'b0;
         Hi     <= '0;
         Lo     <= '0;
      end else begin
         state <= state_n;
         dz_q  <= accept && dz;
         if (accept && (op_mul || (op_div && !dz))) begin
            acc    <= '0;
            opd    <= op_div ? {{DATA_W{1'b0}}, b_mag} : {{DATA_W{1'b0}}, a_mag};
            sreg   <= op_div ? a_mag : b_mag;
            is_div <= op_div;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            cnt    <= CNT_W'(N);
         end else if (state == S_CALC) begin
            acc  <= acc_n;
            opd  <= opd_n;
            sreg <= sreg_n;
            cnt  <= cnt - 1'b1;
         end
         if (state == S_FIX && !Flush) begin
            Hi <= is_div ? rem_fix : prod_fix[2*DATA_W-1:DATA_W];
            Lo <= is_div ? quot_fix : prod_fix[DATA_W-1:0];
         end
         if (accept && Op == 3'b100) Hi <= A;
         if (accept && Op == 3'b101) Lo <= A;
      end
   end

   assign Busy      = (state == S_CALC) || (state == S_FIX);
   assign Done      = (state == S_DONE);
   assign DivByZero = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, HI/LO results, divide-by-zero, flush, reset and MTHI/MTLO.
module tb_muldiv_unit;

   logic        Clk = 1'b0;
   logic        Rst = 1'b0;
   logic        Start = 1'b0;
   logic [2:0]  Op = 3'b000;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        Flush = 1'b0;
   logic        Busy, Done, DivByZero;
   logic [31:0] Hi, Lo;

   int errors = 0;
   int checks = 0;

   localparam logic [2:0] OP_MULT = 3'b000, OP_MULTU = 3'b001, OP_DIV = 3'b010,
                          OP_DIVU = 3'b011, OP_MTHI = 3'b100, OP_MTLO = 3'b101;

   muldiv_unit #(.DATA_W(32), .STEPS_PER_CLK(1)) dut (
      .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B), .Flush(Flush),
      .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .Hi(Hi), .Lo(Lo)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Presents a request for the sampling edge, returns #1 into cycle 1.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge Clk);
      Start = 1'b1; Op = op; A = a; B = b;
      @(posedge Clk); #1;
      Start = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) begin @(posedge Clk); #1; end
   endtask

   // Starting in cycle c0, waits for Done; counts Busy cycles seen before it.
   task automatic wait_done(input int c0, output int done_cyc, output int busy_cnt);
      int c;
      c = c0; done_cyc = -1; busy_cnt = 0;
      while (c <= 120) begin
         if (Done) begin done_cyc = c; break; end
         if (Busy) busy_cnt++;
         step(1);
         c++;
      end
   endtask

   task automatic count_done(input int n, output int seen);
      seen = 0;
      repeat (n) begin
         if (Done) seen++;
         step(1);
      end
   endtask

   task automatic run_full(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] hi_e, input logic [31:0] lo_e);
      int dc, bc;
      issue(op, a, b);
      wait_done(1, dc, bc);
      chk({tag, "_done_cyc"}, 64'(dc), 64'd34);
      chk({tag, "_busy_cnt"}, 64'(bc), 64'd33);
      chk({tag, "_hi"}, 64'(Hi), 64'(hi_e));
      chk({tag, "_lo"}, 64'(Lo), 64'(lo_e));
      step(1);
      chk({tag, "_done_pulse"}, 64'(Done), 64'd0);
   endtask

   initial begin
      int dc, bc, seen;

      step(2);
      Rst = 1'b1;
      issue(OP_MTHI, 32'h55, 32'h0);
      issue(OP_MULTU, 32'h1234, 32'h5678);
      step(3);
      Rst = 1'b0;
      step(2);
      Rst = 1'b1;
      chk("rst_hi", 64'(Hi), 64'd0);
      chk("rst_lo", 64'(Lo), 64'd0);
      chk("rst_busy", 64'(Busy), 64'd0);
      chk("rst_done", 64'(Done), 64'd0);
      chk("rst_dbz", 64'(DivByZero), 64'd0);

      run_full("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_full("div_neg7", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_full("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
      run_full("mult_minsq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
      run_full("div_wrap", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
      run_full("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      run_full("div_negdiv", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);

      // MTHI then MTLO on back-to-back edges
      @(negedge Clk);
      Start = 1'b1; Op = OP_MTHI; A = 32'hDEAD_BEEF;
      @(posedge Clk); #1;
      chk("mthi_hi", 64'(Hi), 64'hDEAD_BEEF);
      chk("mthi_busy", 64'(Busy), 64'd0);
      @(negedge Clk);
      Op = OP_MTLO; A = 32'h1234_5678;
      @(posedge Clk); #1;
      Start = 1'b0;
      chk("mtlo_hi", 64'(Hi), 64'hDEAD_BEEF);
      chk("mtlo_lo", 64'(Lo), 64'h1234_5678);
      chk("mtlo_busy", 64'(Busy), 64'd0);
      chk("mtlo_done", 64'(Done), 64'd0);

      issue(OP_MTHI, 32'h11, 32'h0);
      issue(OP_MTLO, 32'h22, 32'h0);
      issue(OP_DIVU, 32'd5, 32'd0);
      chk("dbz_done", 64'(Done), 64'd1);
      chk("dbz_flag", 64'(DivByZero), 64'd1);
      chk("dbz_busy", 64'(Busy), 64'd0);
      chk("dbz_hi", 64'(Hi), 64'h11);
      chk("dbz_lo", 64'(Lo), 64'h22);
      step(1);
      chk("dbz_pulse", 64'({Done, DivByZero}), 64'd0);

      issue(3'b110, 32'h99, 32'h99);
      chk("rsv_busy", 64'(Busy), 64'd0);
      step(1);
      chk("rsv_done", 64'(Done), 64'd0);
      chk("rsv_hilo", {Hi, Lo}, {32'h11, 32'h22});

      issue(OP_MULT, 32'd3, 32'd4);
      step(9);
      Flush = 1'b1;
      step(1);
      Flush = 1'b0;
      chk("flush_busy", 64'(Busy), 64'd0);
      count_done(40, seen);
      chk("flush_nodone", 64'(seen), 64'd0);
      chk("flush_hilo", {Hi, Lo}, {32'h11, 32'h22});

      issue(OP_DIV, 32'hFFFF_FF9C, 32'd7);
      step(4);
      Start = 1'b1; Op = OP_MULTU; A = 32'd2; B = 32'd3;
      step(1);
      Start = 1'b0;
      wait_done(6, dc, bc);
      chk("busy_ign_cyc", 64'(dc), 64'd34);
      chk("busy_ign_hi", 64'(Hi), 64'hFFFF_FFFE);
      chk("busy_ign_lo", 64'(Lo), 64'hFFFF_FFF2);
      step(1);

      issue(OP_DIVU, 32'd1000, 32'd3);
      step(19);
      Rst = 1'b0;
      step(1);
      Rst = 1'b1;
      chk("midrst_hilo", {Hi, Lo}, 64'd0);
      chk("midrst_busy", 64'(Busy), 64'd0);
      count_done(40, seen);
      chk("midrst_nodone", 64'(seen), 64'd0);

`ifdef MULDIV_EARLY_TERM_EN
      issue(OP_MULTU, 32'd9, 32'd3);
      wait_done(1, dc, bc);
      chk("early_le4", 64'(dc >= 1 && dc <= 4), 64'd1);
      chk("early_lo", 64'(Lo), 64'd27);
      chk("early_hi", 64'(Hi), 64'd0);
      step(1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit beside the EX stage of the 5-stage MIPS pipeline, owning the architectural HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Drives Busy so hazard logic can stall IF/ID/EX while an operation is in flight. MFHI/MFLO read Hi/Lo combinationally from this block's outputs.

Parameters:
- DATA_W, 32, operand width; Hi and Lo are DATA_W each.
- STEPS_PER_CLK, 1, radix steps per CALC cycle; legal values 1, 2, 4; must divide DATA_W. Define N = DATA_W/STEPS_PER_CLK.

Ports:
- Clk  input  1  pipeline clock; all state changes on the rising edge.
- Rst  input  1  reset, synchronous, active-low.
- Start  input  1  operation request from EX; sampled on the rising edge.
- Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
- A  input  DATA_W  rs operand (multiplicand / dividend / MTHI/MTLO data).
- B  input  DATA_W  rt operand (multiplier / divisor).
- Flush  input  1  abandons any in-flight operation.
- Busy  output  1  operation in progress; pipeline must stall any HI/LO access.
- Done  output  1  one-cycle pulse: Hi/Lo hold the new result.
- DivByZero  output  1  one-cycle pulse together with Done for a zero divisor.
- Hi  output  DATA_W  HI register (product high half / remainder).
- Lo  output  DATA_W  LO register (product low half / quotient).

Behaviour:
- Reset: Rst=0 at a rising edge forces state IDLE and Hi=Lo=0. It also clears Busy, Done, DivByZero and the iteration counter. Reset mid-operation discards the operation, with no Done.
- Timing reference: "cycle 0" is the cycle in which Start=1 is sampled.
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE, Start=1 with MULT/MULTU/DIV/DIVU and a nonzero divisor:
  - Latch operand magnitudes (absolute values for signed ops) and the result sign.
  - Load counter = N; go to CALC.
- CALC: one shift-add (multiply) or restoring shift-subtract (divide) group per cycle. The counter decrements; when it reaches 1, go to FIX.
- FIX: apply sign and write Hi/Lo; go to DONE.
  - MULT: the 2*DATA_W product is negated if the operand signs differ.
  - DIV: the quotient is negated if the signs differ; the remainder takes the dividend's sign.
- DONE: Done=1 for exactly one cycle, then IDLE. A Start accepted in DONE is handled as in IDLE.
- Latency: Busy=1 in cycles 1..N+1; Done=1 in cycle N+2 (cycle 34 at defaults). Hi/Lo are stable from cycle N+2.
- Divide by zero (DIV/DIVU, B==0): go IDLE->DONE directly. Done=DivByZero=1 in cycle 1; Busy never asserts; Hi/Lo unchanged.
- MTHI/MTLO: write A into Hi/Lo at the sampling edge. Takes effect in cycle 1; no Busy, no Done. Accepted only in IDLE/DONE.
- Start while Busy=1 is ignored; the operation in flight continues unaffected. Reserved Op values are ignored.
- Flush=1 in any state returns to IDLE next edge. Busy drops and no Done is produced; Hi/Lo keep their pre-operation values. Flush wins over a simultaneous Start.
- Width rules:
  - Signed MULT of 0x80000000 by itself: Hi=0x40000000, Lo=0.
  - DIV of 0x80000000 by 0xFFFFFFFF: Lo=0x80000000 (wraps), Hi=0.
  - Unsigned ops never negate.
- Hi/Lo change only at FIX, at MTHI/MTLO, or at reset.

Optional Feature:
- Macro: MULDIV_EARLY_TERM_EN.
- Defined: during MULT/MULTU, CALC exits to FIX at the end of any cycle where the remaining multiplier bits are all zero. CALC still lasts at least 1 cycle. Busy/Done shift earlier accordingly. Divides are unaffected.
- Undefined: fixed N-cycle CALC for all operations.

Test Plan:
- Rst=0 for 2 cycles after arbitrary traffic -> Hi=Lo=0, Busy=Done=DivByZero=0.
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> Busy cycles 1..33, Done cycle 34, Hi=0xFFFFFFFE, Lo=0x00000001. With MULDIV_EARLY_TERM_EN, MULTU B=3 -> Done no later than cycle 4.
- DIV A=0xFFFFFFF9 (-7) B=2 -> Done cycle 34, Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU A=100 B=7 -> Lo=14, Hi=2.
- DIVU A=5 B=0 with Hi=0x11, Lo=0x22 -> Done=DivByZero=1 in cycle 1, Busy=0, Hi=0x11, Lo=0x22.
- MULT started, Flush=1 in cycle 10 -> Busy=0 from cycle 11, no Done, Hi/Lo unchanged. Start (MULTU) during cycle 5 of a DIV -> ignored, DIV result correct.
- MTHI A=0xDEADBEEF then MTLO A=0x12345678 on consecutive cycles -> Hi=0xDEADBEEF, Lo=0x12345678, Busy stays 0. Rst=0 in cycle 20 of a DIV -> Hi=Lo=0, no Done.
